onewire_txn_ctrl: RTL
=====================

# onewire_txn_ctrl

Byte-level transaction sequencer for the 1-wire master. It accepts RESET / WRITE-byte / READ-byte / CRC-clear commands from a host-side requester and breaks each one into single-bit slot requests for the bit-timing engine. It collects read bits LSB-first, keeps a running Maxim CRC-8 over read data, and guards every slot with a watchdog. It sits between system control logic (e.g. a temperature-polling FSM) and the slot engine that drives the open-drain port.

## Interface
- TIMEOUT, 100000 — max clk cycles from slot_req rise to slot_done before abort; counter width $clog2(TIMEOUT+1).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 RESET, 01 WRITE, 10 READ, 11 CRC_CLR.
- cmd_wdata  in  8  byte to write; sampled at accept.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  assembled read byte (READ); 0x00 for other ops.
- rsp_presence  out  1  presence result of last RESET op (held until next RESET).
- rsp_err  out  1  valid with rsp_valid: timeout, or RESET with no presence.
- crc  out  8  running CRC-8 (poly x^8+x^5+x^4+1, reflected 0x8C, init 0x00).
- crc_ok  out  1  crc == 0x00.
- slot_req  out  1  slot request to the engine; held until slot_done.
- slot_op  out  2  00 reset/presence, 01 write bit, 10 read bit.
- slot_wbit  out  1  bit to write; stable while slot_req is high.
- slot_done  in  1  one-cycle pulse from the engine at slot end.
- slot_rbit  in  1  sampled bus bit; valid with slot_done for read slots.
- slot_presence  in  1  1 = slave pulled low; valid with slot_done for reset slots.

## Operation
- FSM states: IDLE, SLOT, GAP, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op and wdata, clear bitcnt (3-bit).
  - CRC_CLR: go to RESP.
  - All other ops: go to SLOT.
- SLOT: slot_req=1; slot_op from the op; slot_wbit = wdata[bitcnt]. Watchdog counts.
  - On slot_done, slot_req drops the next cycle.
  - READ: rdata[bitcnt] <= slot_rbit. CRC update: fb = crc[0]^bit; crc <= (crc>>1) ^ (fb ? 0x8C : 0).
  - RESET: presence <= slot_presence; crc <= 0.
  - If op is RESET or bitcnt==7, go to RESP. Otherwise bitcnt++ and go to GAP.
- GAP: one cycle with slot_req=0, then back to SLOT. This guarantees the engine sees a fresh request edge.
- Watchdog expiry in SLOT: slot_req=0, set the err flag, go to RESP. Partial rdata is discarded (reported 0x00). CRC keeps the bits already absorbed.
- RESP: rsp_valid=1 for one cycle. rsp_err = timeout | (op==RESET & ~presence). Then go to IDLE.
- Bits are sent and received LSB first.
- WRITE slots do not touch the CRC.
- Commands presented while busy are not accepted; cmd_ready is low.

## Timing
- Reset values:
  - state IDLE, cmd_ready=1.
  - slot_req=0, slot_op=00, slot_wbit=0.
  - rsp_valid=0, rsp_rdata=0x00, rsp_presence=0, rsp_err=0.
  - crc=0x00, crc_ok=1.
  - Watchdog and bitcnt 0.
- Reset asserted mid-transaction: slot_req drops immediately (async). The transaction is lost and no rsp_valid is produced.
- Accept at edge N → slot_req high from N+1.
- Byte op: 8 slots. Each slot_done is followed by a 1-cycle low gap. rsp_valid rises the cycle after the 8th slot_done is sampled.
- RESET op: rsp_valid the cycle after its single slot_done.
- CRC_CLR: rsp_valid at N+1; crc reads 0x00 from N+1.
- slot_done outside SLOT is ignored.
- slot_done in the same cycle as watchdog expiry: slot_done wins and no error is flagged.
- crc and rsp_rdata are stable when rsp_valid is high.
- The next command is accepted at the earliest the cycle after rsp_valid.

## Structure
- Shared package onewire_pkg holds:
  - op/slot-op enums (OW_RESET=2'b00, OW_WRITE=2'b01, OW_READ=2'b10, OW_CRCCLR=2'b11).
  - CRC polynomial constant 8'h8C.
  - Function crc8_bit(crc, bit).
- One natural sub-module, onewire_crc8: CRC register with clear / bit-enable inputs. The FSM, shift registers and watchdog stay in the top module.

## Test plan
- RESET op, engine returns slot_presence=1 → one slot with slot_op=00, rsp_valid with rsp_presence=1, rsp_err=0, crc=0x00.
- RESET op, slot_presence=0 → rsp_presence=0, rsp_err=1.
- WRITE 0xCC → slot_wbit sequence 0,0,1,1,0,0,1,1. Exactly 8 slot_req pulses with a 1-cycle gap each. rsp_rdata=0x00, crc unchanged.
- CRC check:
  - CRC_CLR, then READ with slot_rbit stream for 0x01 → rsp_rdata=0x01, crc=0x5E.
  - A further READ of 0x5E → crc=0x00, crc_ok=1.
- TIMEOUT=50, engine never answers on bit 3 of a READ → slot_req drops 50 cycles after its rise, rsp_valid with rsp_err=1 and rsp_rdata=0x00, then cmd_ready=1.
- Async reset during bit 5 of a WRITE → slot_req=0 and all outputs at their reset values at once, no rsp_valid. A following RESET op completes normally.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared types and CRC helper for the 1-wire transaction sequencer.
// Op codes, slot codes, FSM states and the Maxim CRC-8 bit step.
package onewire_pkg;

  typedef enum logic [1:0] {
    OW_RESET  = 2'b00,
    OW_WRITE  = 2'b01,
    OW_READ   = 2'b10,
    OW_CRCCLR = 2'b11
  } ow_op_e;

  typedef enum logic [1:0] {
    SL_RESET = 2'b00,
    SL_WRITE = 2'b01,
    SL_READ  = 2'b10
  } slot_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT,
    ST_GAP,
    ST_RESP
  } ow_state_e;

  localparam logic [7:0] CRC_POLY = 8'h8C;

  function automatic logic [7:0] crc8_bit(
    input logic [7:0] c,
    input logic       b
  );
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Running Maxim CRC-8 register over read bits.
// Clear has priority over a bit update in the same cycle.
module onewire_crc8
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  // next CRC value: clear, absorb one bit, or hold
  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = crc8_bit(crc_q, bit_i);
    end
  end

  // CRC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/onewire_txn_ctrl.sv
// Byte-level 1-wire transaction sequencer: splits host commands
// into bit slots, assembles read bytes and guards each slot.
module onewire_txn_ctrl
  import onewire_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_presence,
  output logic       rsp_err,
  output logic [7:0] crc,
  output logic       crc_ok,
  output logic       slot_req,
  output logic [1:0] slot_op,
  output logic       slot_wbit,
  input  logic       slot_done,
  input  logic       slot_rbit,
  input  logic       slot_presence
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  ow_state_e     state_q, state_d;
  ow_op_e        op_q, op_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          pres_q, pres_d;
  logic          crc_clr, crc_en;
  ow_op_e        cmd_op_e;

  assign cmd_op_e = ow_op_e'(cmd_op);

  // next-state and datapath updates of the sequencer
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bitcnt_d = bitcnt_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    pres_d   = pres_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op_e;
          wdata_d  = cmd_wdata;
          rdata_d  = 8'h00;
          bitcnt_d = 3'd0;
          wdog_d   = '0;
          err_d    = 1'b0;
          if (cmd_op_e == OW_RESET) begin
            pres_d = 1'b0;
          end
          if (cmd_op_e == OW_CRCCLR) begin
            crc_clr = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_SLOT;
          end
        end
      end
      ST_SLOT: begin
        if (slot_done) begin
          wdog_d = '0;
          if (op_q == OW_READ) begin
            rdata_d[bitcnt_q] = slot_rbit;
            crc_en = 1'b1;
          end
          if (op_q == OW_RESET) begin
            pres_d  = slot_presence;
            crc_clr = 1'b1;
          end
          if (op_q == OW_RESET || bitcnt_q == 3'd7) begin
            state_d = ST_RESP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = ST_GAP;
          end
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_SLOT;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sequencer state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OW_RESET;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      pres_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bitcnt_q <= bitcnt_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      pres_q   <= pres_d;
    end
  end

  onewire_crc8 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (slot_rbit),
    .crc_o (crc)
  );

  assign cmd_ready    = (state_q == ST_IDLE);
  assign slot_req     = (state_q == ST_SLOT);
  assign slot_op      = slot_req ? op_q : SL_RESET;
  assign slot_wbit    = slot_req & wdata_q[bitcnt_q];
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_presence = pres_q;
  assign rsp_err      = rsp_valid &
                        (err_q | (op_q == OW_RESET & ~pres_q));
  assign rsp_rdata    = (rsp_valid && op_q == OW_READ && !err_q)
                        ? rdata_q : 8'h00;
  assign crc_ok       = (crc == 8'h00);

endmodule
